cs_approx_avg: RTL and testbench



---
 rtl/cs_pkg.sv | 18 +
 rtl/cs_appr_sel.sv | 31 +++
 rtl/cs_approx_avg.sv | 71 +++++++
 tb/tb_cs_approx_avg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared sizes, window type and helpers for the cs_approx_avg filter.
// The optional CS_VALID_EN macro is consumed by the top module only.
`timescale 1ns/1ps
package cs_pkg;
    localparam int IN_W  = 8;
    localparam int OUT_W = 10;
    localparam int WIN   = 9;
    localparam int SUM_W = 12;
    localparam int TOT_W = 13;

    // Entry 0 is the newest sample, entry WIN-1 the oldest.
    typedef logic [WIN-1:0][IN_W-1:0] win_t;

    function automatic logic [IN_W-1:0] max2(input logic [IN_W-1:0] a,
                                             input logic [IN_W-1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/cs_appr_sel.sv
// Picks the largest window sample not exceeding xavg: mask each entry
// that is too large, then reduce the survivors with a max tree.
`timescale 1ns/1ps
module cs_appr_sel
    import cs_pkg::*;
(
    input  logic [WIN-1:0][IN_W-1:0] win,
    input  logic [IN_W-1:0]          xavg,
    output logic [IN_W-1:0]          xappr
);
    logic [IN_W-1:0] masked [WIN];
    logic [IN_W-1:0] lvl1   [4];
    logic [IN_W-1:0] lvl2   [2];
    logic [IN_W-1:0] lvl3;

    // A masked entry becomes 0, which never beats a genuine candidate.
    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            masked[i] = (win[i] <= xavg) ? win[i] : '0;
        end
    end

    assign lvl1[0] = max2(masked[0], masked[1]);
    assign lvl1[1] = max2(masked[2], masked[3]);
    assign lvl1[2] = max2(masked[4], masked[5]);
    assign lvl1[3] = max2(masked[6], masked[7]);
    assign lvl2[0] = max2(lvl1[0], lvl1[1]);
    assign lvl2[1] = max2(lvl1[2], lvl1[3]);
    assign lvl3    = max2(lvl2[0], lvl2[1]);
    assign xappr   = max2(lvl3, masked[8]);
endmodule

// File: rtl/cs_approx_avg.sv
// Streaming approximate-average filter: Y = floor((S + 9*Xappr)/8) over the
// last 9 samples. Define CS_VALID_EN to add the Y_valid fill indicator.
`timescale 1ns/1ps
module cs_approx_avg
    import cs_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  X,
    output logic [OUT_W-1:0] Y
`ifdef CS_VALID_EN
    ,
    output logic             Y_valid
`endif
);
    // floor(S/9) == (S*3641) >> 15 exactly for S <= 2295 (3641*9 = 2^15+1).
    localparam logic [23:0] RECIP9 = 24'd3641;

    win_t             win_q;
    win_t             win_d;
    logic [SUM_W-1:0] sum;
    logic [23:0]      prod;
    logic [IN_W-1:0]  xavg;
    logic [IN_W-1:0]  xappr;
    logic [TOT_W-1:0] tot;

    assign win_d = {win_q[WIN-2:0], X};

    always_comb begin
        sum = '0;
        for (int i = 0; i < WIN; i++) begin
            sum = sum + SUM_W'(win_d[i]);
        end
    end

    assign prod = 24'(sum) * RECIP9;
    assign xavg = IN_W'(prod >> 15);

    cs_appr_sel u_sel (
        .win   (win_d),
        .xavg  (xavg),
        .xappr (xappr)
    );

    assign tot = TOT_W'(sum) + (TOT_W'(xappr) << 3) + TOT_W'(xappr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= '0;
            Y     <= '0;
        end else begin
            win_q <= win_d;
            Y     <= OUT_W'(tot >> 3);
        end
    end

`ifdef CS_VALID_EN
    logic [3:0] fill_cnt;

    // Y_valid rises on the edge that captures the ninth sample (count 8 -> 9).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_cnt <= '0;
            Y_valid  <= 1'b0;
        end else begin
            if (fill_cnt < 4'(WIN)) fill_cnt <= fill_cnt + 4'd1;
            if (fill_cnt >= 4'(WIN - 1)) Y_valid <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cs_approx_avg.sv
// Self-checking bench for cs_approx_avg: directed scenarios plus a random
// sweep, each output compared against an independent golden model.
`timescale 1ns/1ps
module tb_cs_approx_avg;
    logic       clk;
    logic       reset;
    logic [7:0] X;
    logic [9:0] Y;
`ifdef CS_VALID_EN
    logic       Y_valid;
`endif

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    logic [7:0] mwin [9];

    cs_approx_avg dut (
        .clk     (clk),
        .reset   (reset),
        .X       (X),
        .Y       (Y)
`ifdef CS_VALID_EN
        ,
        .Y_valid (Y_valid)
`endif
    );

    // 7 ns clock
    initial clk = 1'b0;
    always #3.5 clk = ~clk;

    function automatic logic [9:0] model_y();
        int s, avg, appr;
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(mwin[i]);
        avg  = s / 9;
        appr = 0;
        for (int i = 0; i < 9; i++)
            if (int'(mwin[i]) <= avg && int'(mwin[i]) > appr) appr = int'(mwin[i]);
        return 10'((s + 9 * appr) / 8);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) mwin[i] = 8'd0;
        exp_q.delete();
    endtask

    // Drive one sample, push its expected result, return 1 ns after the edge.
    task automatic drive(input logic [7:0] x);
        X = x;
        for (int i = 8; i > 0; i--) mwin[i] = mwin[i-1];
        mwin[0] = x;
        exp_q.push_back(model_y());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        reset = 1'b1;
        X = 8'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (Y !== 10'd0) begin
            errors++;
            $display("FAIL reset_y: got %0d expected 0", Y);
        end
        reset = 1'b0;
        drive(8'd0);
        exp = exp_q.pop_front();
        checks++;
        if (Y !== exp) begin
            errors++;
            $display("FAIL reset_first: got %0d expected %0d", Y, exp);
        end
    endtask

    task automatic test_constant();
        logic [9:0] exp;
        for (int i = 0; i < 12; i++) begin
            drive(8'd10);
            exp = exp_q.pop_front();
            checks++;
            if (Y !== exp) begin
                errors++;
                $display("FAIL constant_step%0d: got %0d expected %0d", i, Y, exp);
            end
        end
        checks++;
        if (Y !== 10'd22) begin
            errors++;
            $display("FAIL constant_final: got %0d expected 22", Y);
        end
    endtask

    task automatic test_ramp();
        logic [9:0] exp;
        for (int i = 1; i <= 9; i++) begin
            drive(8'(i));
            exp = exp_q.pop_front();
            checks++;
            if (Y !== exp) begin
                errors++;
                $display("FAIL ramp_step%0d: got %0d expected %0d", i, Y, exp);
            end
        end
        checks++;
        if (Y !== 10'd11) begin
            errors++;
            $display("FAIL ramp_final: got %0d expected 11", Y);
        end
    endtask

    task automatic test_no_match();
        logic [9:0] exp;
        for (int i = 0; i < 8; i++) begin
            drive(8'd0);
            void'(exp_q.pop_front());
        end
        drive(8'd90);
        exp = exp_q.pop_front();
        checks++;
        if (Y !== 10'd11 || Y !== exp) begin
            errors++;
            $display("FAIL no_match_first: got %0d expected 11 (model %0d)", Y, exp);
        end
        // 90 stays for 8 more edges, then leaves on the 9th.
        for (int i = 1; i <= 9; i++) begin
            drive(8'd0);
            exp = exp_q.pop_front();
            checks++;
            if (Y !== exp || Y !== ((i < 9) ? 10'd11 : 10'd0)) begin
                errors++;
                $display("FAIL no_match_tail%0d: got %0d expected %0d", i, Y, exp);
            end
        end
    endtask

    task automatic test_max();
        logic [9:0] exp;
        for (int i = 0; i < 9; i++) begin
            drive(8'd255);
            exp = exp_q.pop_front();
            checks++;
            if (Y !== exp) begin
                errors++;
                $display("FAIL max_step%0d: got %0d expected %0d", i, Y, exp);
            end
        end
        checks++;
        if (Y !== 10'd573) begin
            errors++;
            $display("FAIL max_final: got %0d expected 573", Y);
        end
    endtask

    task automatic test_partial();
        logic [9:0] exp;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(8'd90);
        exp = exp_q.pop_front();
        checks++;
        if (Y !== 10'd11 || Y !== exp) begin
            errors++;
            $display("FAIL partial_first: got %0d expected 11 (model %0d)", Y, exp);
        end
        for (int i = 0; i < 3; i++) begin
            drive(8'd0);
            exp = exp_q.pop_front();
            checks++;
            if (Y !== exp) begin
                errors++;
                $display("FAIL partial_zero%0d: got %0d expected %0d", i, Y, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] exp;
        for (int i = 0; i < 9; i++) begin
            drive(8'd10);
            void'(exp_q.pop_front());
        end
        checks++;
        if (Y !== 10'd22) begin
            errors++;
            $display("FAIL mid_reset_pre: got %0d expected 22", Y);
        end
        // Assert reset between edges; Y must drop without a clock.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (Y !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_async: got %0d expected 0", Y);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            drive(8'd10);
            exp = exp_q.pop_front();
            checks++;
            if (Y !== exp) begin
                errors++;
                $display("FAIL mid_reset_refill%0d: got %0d expected %0d", i, Y, exp);
            end
            if (i == 1) begin
                checks++;
                if (Y !== 10'd1) begin
                    errors++;
                    $display("FAIL mid_reset_first: got %0d expected 1", Y);
                end
            end
        end
        checks++;
        if (Y !== 10'd22) begin
            errors++;
            $display("FAIL mid_reset_full: got %0d expected 22", Y);
        end
    endtask

    task automatic test_random();
        logic [9:0] exp;
        logic [9:0] held;
        logic [7:0] x;
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0:       x = 8'($urandom_range(0, 15));
                1:       x = 8'($urandom_range(240, 255));
                default: x = 8'($urandom_range(0, 255));
            endcase
            drive(x);
            exp = exp_q.pop_front();
            checks++;
            if (Y !== exp) begin
                errors++;
                $display("FAIL random%0d: got %0d expected %0d (x=%0d)", i, Y, exp, x);
            end
            held = Y;
            #5.5;
            checks++;
            if (Y !== held) begin
                errors++;
                $display("FAIL stable%0d: got %0d expected %0d", i, Y, held);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        X = 8'd0;
        test_reset();
        test_constant();
        test_ramp();
        test_no_match();
        test_max();
        test_partial();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
